// File: rtl/td4_prog_ctrl_if.sv
// Program-store loader port for td4_prog_ctrl: the host writes one byte
// per accepted valid/ready beat.
interface td4_prog_ctrl_if;
    logic       ld_valid;
    logic       ld_ready;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;

    modport master (
        output ld_valid,
        output ld_addr,
        output ld_data,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_addr,
        input  ld_data,
        output ld_ready
    );
endinterface

// File: rtl/td4_prog_ctrl.sv
// Program-memory and run controller for the TD4 4-bit core.
// Holds a 16x8 writable program store, serves it to the core's ROM pins and
// sequences the core through reset, run, halt, single-step and breakpoint.
// While the core must not advance it is fed JMP-to-self, which freezes the
// PC and leaves A and B untouched.
module td4_prog_ctrl #(
    parameter int unsigned RST_CYCLES = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    td4_prog_ctrl_if.slave   ld,
    input  logic             cmd_run,
    input  logic             cmd_halt,
    input  logic             cmd_step,
    input  logic             cmd_reset,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    output logic             core_clr_n,
    input  logic [3:0]       core_addr,
    output logic [7:0]       core_data,
    output logic             halted,
    output logic             step_done,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned     RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_HALT,
        S_STEP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      store [16];
    logic [RC_W-1:0] rst_cnt;
    logic            bp_skip;

    logic            hit;
    logic            exec;
    logic            rst_start;
    logic            ld_ok;

    // Next-state selection, breakpoint detection and execute qualification
    always_comb begin
        state_next = state;
        hit        = (state == S_RUN) && bp_en && (core_addr == bp_addr) && !bp_skip;
        exec       = ((state == S_RUN) && !hit) || (state == S_STEP);

        unique case (state)
            S_IDLE: begin
                if (cmd_run) state_next = S_RESET;
            end
            S_RESET: begin
                if (cmd_reset)               state_next = S_RESET;
                else if (rst_cnt == RC_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                if (cmd_reset)            state_next = S_RESET;
                else if (hit || cmd_halt) state_next = S_HALT;
            end
            S_HALT: begin
                if (cmd_reset)     state_next = S_RESET;
                else if (cmd_step) state_next = S_STEP;
                else if (cmd_run)  state_next = S_RUN;
            end
            S_STEP: begin
                if (cmd_reset) state_next = S_RESET;
                else           state_next = S_HALT;
            end
            default: state_next = S_IDLE;
        endcase

        // A fresh count starts on any entry into RESET, including a re-issued
        // cmd_reset while already counting.
        rst_start = (state_next == S_RESET) && ((state != S_RESET) || cmd_reset);
    end

    assign ld_ok       = (state == S_IDLE) || (state == S_HALT);
    assign ld.ld_ready = ld_ok;
    assign halted      = (state == S_HALT);
    assign core_data   = exec ? store[core_addr] : {4'b1111, core_addr};

    // State, reset counter, status pulses, instruction counter and program store
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            bp_skip     <= 1'b0;
            core_clr_n  <= 1'b0;
            step_done   <= 1'b0;
            bp_hit      <= 1'b0;
            instr_count <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                store[i] <= '0;
            end
        end else begin
            state      <= state_next;
            core_clr_n <= (state_next == S_RUN) || (state_next == S_HALT) ||
                          (state_next == S_STEP);
            step_done  <= (state == S_STEP) && (state_next == S_HALT);
            bp_hit     <= hit && (state_next == S_HALT);

            if (rst_start)             rst_cnt <= '0;
            else if (state == S_RESET) rst_cnt <= rst_cnt + RC_W'(1);

            if ((state == S_HALT) && (state_next == S_RUN)) bp_skip <= 1'b1;
            else if (state == S_RUN)                        bp_skip <= 1'b0;

            if (rst_start)
                instr_count <= '0;
            else if (exec && (instr_count != '1))
                instr_count <= instr_count + CNT_W'(1);

            if (ld.ld_valid && ld_ok) store[ld.ld_addr] <= ld.ld_data;
        end
    end

endmodule

// File: tb/tb_td4_prog_ctrl.sv
// Bench for td4_prog_ctrl: a minimal TD4 core (OUT im, JMP im, others advance
// the PC) closes the loop on the ROM pins, a behavioural model predicts every
// output each cycle, and directed literal checks pin the scenarios.
module tb_td4_prog_ctrl;

    localparam int RST      = 3;
    localparam int CNT_MAX  = 65535;
    localparam int CNT_MAX2 = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n, cmd_run, cmd_halt, cmd_step, cmd_reset, bp_en;
    logic [3:0]  bp_addr;
    logic        core_clr_n, halted, step_done, bp_hit;
    logic [7:0]  core_data;
    logic [15:0] instr_count;
    logic        core_clr_n2, halted2, step_done2, bp_hit2;
    logic [7:0]  core_data2;
    logic [3:0]  instr_count2;

    td4_prog_ctrl_if ld_if ();
    td4_prog_ctrl_if ld_if2 ();
    assign ld_if2.ld_valid = ld_if.ld_valid;
    assign ld_if2.ld_addr  = ld_if.ld_addr;
    assign ld_if2.ld_data  = ld_if.ld_data;

    // minimal TD4 core
    logic [3:0] pc, core_out;
    always @(posedge clk) begin
        if (!core_clr_n) begin
            pc       <= 4'd0;
            core_out <= 4'd0;
        end else begin
            case (core_data[7:4])
                4'hB: begin core_out <= core_data[3:0]; pc <= pc + 4'd1; end
                4'hF: pc <= core_data[3:0];
                default: pc <= pc + 4'd1;
            endcase
        end
    end

    td4_prog_ctrl #(.RST_CYCLES(RST), .CNT_W(16)) dut (
        .clk(clk), .clr_n(clr_n), .ld(ld_if),
        .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step), .cmd_reset(cmd_reset),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .core_clr_n(core_clr_n), .core_addr(pc), .core_data(core_data),
        .halted(halted), .step_done(step_done), .bp_hit(bp_hit), .instr_count(instr_count)
    );

    td4_prog_ctrl #(.RST_CYCLES(RST), .CNT_W(4)) dut_small (
        .clk(clk), .clr_n(clr_n), .ld(ld_if2),
        .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step), .cmd_reset(cmd_reset),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .core_clr_n(core_clr_n2), .core_addr(pc), .core_data(core_data2),
        .halted(halted2), .step_done(step_done2), .bp_hit(bp_hit2), .instr_count(instr_count2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [16];
    int m_rst_left;          // reset cycles still to go; >0 means core held in reset
    bit m_run, m_halt, m_step, m_skip, m_bph, m_sd;
    int m_cnt;

    always @(posedge clk) begin
        bit idle, hit, exec;
        if (!clr_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_rst_left = 0;
            {m_run, m_halt, m_step, m_skip, m_bph, m_sd} = '0;
            m_cnt = 0;
        end else begin
            idle = !(m_rst_left > 0 || m_run || m_halt || m_step);
            hit  = m_run && bp_en && (pc == bp_addr) && !m_skip;
            exec = (m_run && !hit) || m_step;
            if ((idle || m_halt) && ld_if.ld_valid) m_mem[ld_if.ld_addr] = ld_if.ld_data;
            if (exec && m_cnt < CNT_MAX) m_cnt++;
            m_bph = 1'b0;
            m_sd  = 1'b0;
            if (idle) begin
                if (cmd_run) begin m_rst_left = RST; m_cnt = 0; end
            end else if (cmd_reset) begin
                m_rst_left = RST;
                {m_run, m_halt, m_step, m_skip} = '0;
                m_cnt = 0;
            end else if (m_rst_left > 0) begin
                m_rst_left--;
                if (m_rst_left == 0) m_run = 1'b1;
            end else if (m_run) begin
                m_skip = 1'b0;
                if (hit || cmd_halt) begin m_run = 1'b0; m_halt = 1'b1; m_bph = hit; end
            end else if (m_halt) begin
                if (cmd_step)     begin m_halt = 1'b0; m_step = 1'b1; end
                else if (cmd_run) begin m_halt = 1'b0; m_run = 1'b1; m_skip = 1'b1; end
            end else if (m_step) begin
                m_step = 1'b0; m_halt = 1'b1; m_sd = 1'b1;
            end
        end
    end

    // every-cycle compare against the model
    always @(negedge clk) begin
        logic [7:0] e_data;
        bit e_exec, e_idle;
        int e_cnt2;
        if (chk_en) begin
            e_idle = !(m_rst_left > 0 || m_run || m_halt || m_step);
            e_exec = (m_run && !(bp_en && pc == bp_addr && !m_skip)) || m_step;
            e_data = e_exec ? m_mem[pc] : {4'hF, pc};
            e_cnt2 = (m_cnt > CNT_MAX2) ? CNT_MAX2 : m_cnt;
            check("m_core_clr_n", 32'(core_clr_n), 32'(m_run || m_halt || m_step));
            check("m_core_data",  32'(core_data),  32'(e_data));
            check("m_halted",     32'(halted),     32'(m_halt));
            check("m_step_done",  32'(step_done),  32'(m_sd));
            check("m_bp_hit",     32'(bp_hit),     32'(m_bph));
            check("m_ld_ready",   32'(ld_if.ld_ready), 32'(e_idle || m_halt));
            check("m_instr_count", 32'(instr_count), 32'(m_cnt));
            check("m_instr_count_small", 32'(instr_count2), 32'(e_cnt2));
            check("m_core_data_small",   32'(core_data2),   32'(e_data));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input bit r, input bit h, input bit s, input bit x);
        cmd_run = r; cmd_halt = h; cmd_step = s; cmd_reset = x;
        tick();
        {cmd_run, cmd_halt, cmd_step, cmd_reset} = '0;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ld_if.ld_valid = 1'b1; ld_if.ld_addr = a; ld_if.ld_data = d;
        tick();
        ld_if.ld_valid = 1'b0;
    endtask

    initial begin
        bit found;
        clr_n = 1'b0;
        {cmd_run, cmd_halt, cmd_step, cmd_reset, bp_en} = '0;
        bp_addr = 4'd0;
        ld_if.ld_valid = 1'b0; ld_if.ld_addr = 4'd0; ld_if.ld_data = 8'h00;
        tick(2);
        chk_en = 1'b1;
        check("rst_core_clr_n", 32'(core_clr_n), 32'd0);
        check("rst_instr_count", 32'(instr_count), 32'd0);
        check("rst_ld_ready", 32'(ld_if.ld_ready), 32'd1);
        check("rst_core_data", 32'(core_data), 32'hF0);
        clr_n = 1'b1;

        // load and run
        load(4'd0, 8'hB5); load(4'd1, 8'hBA); load(4'd2, 8'hF0);
        cmd(1, 0, 0, 0);
        check("run_clr_low_1", 32'(core_clr_n), 32'd0);
        tick(2);
        check("run_clr_low_3", 32'(core_clr_n), 32'd0);
        tick();
        check("run_clr_high", 32'(core_clr_n), 32'd1);
        check("run_data0", 32'(core_data), 32'hB5);
        tick();
        check("run_out5", 32'(core_out), 32'h5);
        check("run_data1", 32'(core_data), 32'hBA);
        check("run_cnt1", 32'(instr_count), 32'd1);
        tick();
        check("run_outA", 32'(core_out), 32'hA);
        check("run_data2", 32'(core_data), 32'hF0);
        tick();
        check("run_wrap_data", 32'(core_data), 32'hB5);
        check("run_cnt3", 32'(instr_count), 32'd3);
        tick(6);

        // breakpoint at address 1
        bp_en = 1'b1; bp_addr = 4'd1;
        cmd(0, 0, 0, 1);
        tick(3);
        check("bp_data0", 32'(core_data), 32'hB5);
        tick();
        check("bp_data_jmp", 32'(core_data), 32'hF1);
        check("bp_out5", 32'(core_out), 32'h5);
        check("bp_cnt1", 32'(instr_count), 32'd1);
        tick();
        check("bp_hit_pulse", 32'(bp_hit), 32'd1);
        check("bp_halted", 32'(halted), 32'd1);
        tick();
        check("bp_hit_clear", 32'(bp_hit), 32'd0);
        check("bp_cnt_frozen", 32'(instr_count), 32'd1);
        check("bp_out_still5", 32'(core_out), 32'h5);

        // single step
        cmd(0, 0, 1, 0);
        check("step_data", 32'(core_data), 32'hBA);
        tick();
        check("step_outA", 32'(core_out), 32'hA);
        check("step_done", 32'(step_done), 32'd1);
        check("step_data_after", 32'(core_data), 32'hF2);
        check("step_halted", 32'(halted), 32'd1);
        tick();

        // resume, hit again, then resume from the breakpoint address
        cmd(1, 0, 0, 0);
        tick(2);
        check("rehit_data", 32'(core_data), 32'hF1);
        tick();
        check("rehit_halted", 32'(halted), 32'd1);
        cmd(1, 0, 0, 0);
        check("skip_data", 32'(core_data), 32'hBA);
        tick();
        check("skip_running", 32'(halted), 32'd0);
        bp_en = 1'b0;

        // loader blocked while running, accepted once halted
        ld_if.ld_valid = 1'b1; ld_if.ld_addr = 4'd0; ld_if.ld_data = 8'hB3;
        tick(3);
        check("ld_blocked", 32'(ld_if.ld_ready), 32'd0);
        cmd(0, 1, 0, 0);
        check("ld_ready_halt", 32'(ld_if.ld_ready), 32'd1);
        tick();
        ld_if.ld_valid = 1'b0;
        cmd(0, 0, 0, 1);
        tick(3);
        check("ld_new_data", 32'(core_data), 32'hB3);
        tick();
        check("ld_out3", 32'(core_out), 32'h3);

        // cmd_reset at addr 2, then again during RESET
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (pc == 4'd2) found = 1'b1;
            else tick();
        end
        check("reach_addr2", 32'(found), 32'd1);
        cmd(0, 0, 0, 1);
        check("rr_clr_low", 32'(core_clr_n), 32'd0);
        check("rr_cnt0", 32'(instr_count), 32'd0);
        tick();
        cmd(0, 0, 0, 1);
        tick(2);
        check("rr_restarted", 32'(core_clr_n), 32'd0);
        tick();
        check("rr_clr_high", 32'(core_clr_n), 32'd1);
        check("rr_addr0", 32'(pc), 32'd0);
        check("rr_cnt_zero", 32'(instr_count), 32'd0);

        // command priority
        tick(2);
        cmd(1, 1, 0, 0);
        check("prio_halt_over_run", 32'(halted), 32'd1);
        cmd(1, 0, 1, 0);
        check("prio_step_over_run", 32'(halted), 32'd0);
        tick();
        check("prio_step_done", 32'(step_done), 32'd1);

        // saturation of the narrow counter
        cmd(0, 0, 0, 1);
        tick(3);
        tick(20);
        check("sat_cnt_wide", 32'(instr_count), 32'd20);
        check("sat_cnt_narrow", 32'(instr_count2), 32'd15);

        // clr_n mid-run clears the store
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        check("clr_idle_ready", 32'(ld_if.ld_ready), 32'd1);
        check("clr_core_low", 32'(core_clr_n), 32'd0);
        cmd(1, 0, 0, 0);
        tick(3);
        check("clr_store_zero", 32'(core_data), 32'h00);
        tick();
        check("clr_nop_advance", 32'(pc), 32'd1);

        tick(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
